// File: rtl/sdram_wr_port.sv
// sdram_wr_port: responder for the drawing pipeline's framebuffer write request.
// One 4-pixel request is captured in IDLE and issued to the SDRAM controller as
// a single 4-beat write burst. The requester gets a one-cycle done pulse back.
// Error status and a completed-request counter are kept for the debug LEDs.

module sdram_wr_port #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        iSDRAM_Wr_Req,
    input  logic [23:0] iSDRAM_Wr_Addr,
    input  logic [15:0] iSDRAM_Wr_Data1,
    input  logic [15:0] iSDRAM_Wr_Data2,
    input  logic [15:0] iSDRAM_Wr_Data3,
    input  logic [15:0] iSDRAM_Wr_Data4,
    output logic        oSDRAM_Wr_Done,

    output logic        oCtl_Cmd_Valid,
    input  logic        iCtl_Cmd_Ready,
    output logic [23:0] oCtl_Addr,
    input  logic        iCtl_Data_Req,
    output logic [15:0] oCtl_Wr_Data,
    input  logic        iCtl_Done,

    output logic        oErr_Align,
    output logic        oErr_Timeout,
    output logic        oErr_Proto,
    output logic [15:0] oWr_Count
);

    // The timeout counter must be able to hold TIMEOUT itself.
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // The counter value during the last BURST cycle before an abort.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_BURST,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [15:0]    words [4];
    logic [2:0]     beat;
    logic [2:0]     beat_after;
    logic [TW-1:0]  tmo_cnt;
    logic [1:0]     beat_idx;

    logic           accept;
    logic           cmd_taken;
    logic           timed_out;
    logic           proto_fault;

    // Next-state decode plus single-cycle event strobes for the datapath.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        cmd_taken   = 1'b0;
        timed_out   = 1'b0;
        proto_fault = 1'b0;
        beat_after  = beat;

        case (state)
            S_IDLE: begin
                if (iSDRAM_Wr_Req) begin
                    accept     = 1'b1;
                    next_state = S_CMD;
                end
            end

            S_CMD: begin
                if (iCtl_Cmd_Ready) begin
                    cmd_taken  = 1'b1;
                    next_state = S_BURST;
                end
            end

            S_BURST: begin
                if (iCtl_Data_Req && (beat < 3'd4)) begin
                    beat_after = beat + 3'd1;
                end
                if (iCtl_Done) begin
                    // A same-cycle data request still counts toward the 4 beats.
                    proto_fault = (beat_after < 3'd4);
                    next_state  = S_ACK;
                end else if (tmo_cnt == TMO_LAST) begin
                    timed_out  = 1'b1;
                    next_state = S_ACK;
                end
            end

            S_ACK: begin
                next_state = S_RELEASE;
            end

            S_RELEASE: begin
                // A request still held high must not start a second write.
                if (!iSDRAM_Wr_Req) begin
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request address (aligned to a 4-word burst) and the four data words.
    always_ff @(posedge clk) begin
        if (rst) begin
            oCtl_Addr <= '0;
            for (int i = 0; i < 4; i++) begin
                words[i] <= '0;
            end
        end else if (accept) begin
            oCtl_Addr <= {iSDRAM_Wr_Addr[23:2], 2'b00};
            words[0]  <= iSDRAM_Wr_Data1;
            words[1]  <= iSDRAM_Wr_Data2;
            words[2]  <= iSDRAM_Wr_Data3;
            words[3]  <= iSDRAM_Wr_Data4;
        end
    end

    // Beat index and abort timer, both restarted when the controller takes the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat    <= '0;
            tmo_cnt <= '0;
        end else if (cmd_taken) begin
            beat    <= '0;
            tmo_cnt <= '0;
        end else if (state == S_BURST) begin
            beat    <= beat_after;
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Registered handshake outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            oCtl_Cmd_Valid <= 1'b0;
            oSDRAM_Wr_Done <= 1'b0;
        end else begin
            oCtl_Cmd_Valid <= (next_state == S_CMD);
            oSDRAM_Wr_Done <= (next_state == S_ACK);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            oErr_Align   <= 1'b0;
            oErr_Timeout <= 1'b0;
            oErr_Proto   <= 1'b0;
        end else begin
            if (accept && (iSDRAM_Wr_Addr[1:0] != 2'b00)) begin
                oErr_Align <= 1'b1;
            end
            if (timed_out) begin
                oErr_Timeout <= 1'b1;
            end
            if (proto_fault) begin
                oErr_Proto <= 1'b1;
            end
        end
    end

    // Completed-request counter; aborted bursts count too, and it wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            oWr_Count <= '0;
        end else if (next_state == S_ACK) begin
            oWr_Count <= oWr_Count + 16'd1;
        end
    end

    // Past the fourth beat the last word is held on the bus.
    always_comb begin
        beat_idx = (beat >= 3'd4) ? 2'd3 : beat[1:0];
    end

    assign oCtl_Wr_Data = words[beat_idx];

endmodule

// File: tb/tb_sdram_wr_port.sv
// tb_sdram_wr_port: table-driven and randomized checks of sdram_wr_port.
// Each transaction is described by a controller plan (ready delay, which burst
// cycles raise a data request, which burst cycle raises done). The expected
// outcome of a plan is either written by hand in the table or derived from the
// handshake rules by the model function.

module tb_sdram_wr_port;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        req;
    logic [23:0] addr_in;
    logic [15:0] d1, d2, d3, d4;
    logic        wr_done;
    logic        cmd_valid;
    logic        ready;
    logic [23:0] ctl_addr;
    logic        data_req;
    logic [15:0] wr_data;
    logic        ctl_done;
    logic        err_align;
    logic        err_tmo;
    logic        err_proto;
    logic [15:0] wr_count;

    int tests_run;
    int tests_failed;

    logic        sticky_align;
    logic        sticky_tmo;
    logic        sticky_proto;
    logic [15:0] exp_count;

    typedef struct {
        logic [23:0]      addr;
        logic [3:0][15:0] data;
        int               ready_delay;
        logic [15:0]      req_mask;
        int               done_j;
        int               hold;
        logic [23:0]      exp_addr;
        int               exp_end_j;
        logic             exp_align;
        logic             exp_tmo;
        logic             exp_proto;
    } vec_t;

    vec_t table_vecs [10];

    sdram_wr_port #(
        .TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .iSDRAM_Wr_Req   (req),
        .iSDRAM_Wr_Addr  (addr_in),
        .iSDRAM_Wr_Data1 (d1),
        .iSDRAM_Wr_Data2 (d2),
        .iSDRAM_Wr_Data3 (d3),
        .iSDRAM_Wr_Data4 (d4),
        .oSDRAM_Wr_Done  (wr_done),
        .oCtl_Cmd_Valid  (cmd_valid),
        .iCtl_Cmd_Ready  (ready),
        .oCtl_Addr       (ctl_addr),
        .iCtl_Data_Req   (data_req),
        .oCtl_Wr_Data    (wr_data),
        .iCtl_Done       (ctl_done),
        .oErr_Align      (err_align),
        .oErr_Timeout    (err_tmo),
        .oErr_Proto      (err_proto),
        .oWr_Count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkvec(input logic [23:0] a, input logic [15:0] w0, input logic [15:0] w1,
                                   input logic [15:0] w2, input logic [15:0] w3, input int rd,
                                   input logic [15:0] mask, input int dj, input int hold,
                                   input logic [23:0] ea, input int ej, input logic al,
                                   input logic tm, input logic pr);
        vec_t v;
        v.addr        = a;
        v.data[0]     = w0;
        v.data[1]     = w1;
        v.data[2]     = w2;
        v.data[3]     = w3;
        v.ready_delay = rd;
        v.req_mask    = mask;
        v.done_j      = dj;
        v.hold        = hold;
        v.exp_addr    = ea;
        v.exp_end_j   = ej;
        v.exp_align   = al;
        v.exp_tmo     = tm;
        v.exp_proto   = pr;
        return v;
    endfunction

    // Expected outcome of a plan from the handshake rules: the burst ends on done
    // if it comes within TMO burst cycles, otherwise on the TMO-th cycle as a timeout.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   nreq;
        r = v;
        r.exp_addr  = v.addr & 24'hFFFFFC;
        r.exp_align = (v.addr % 4) != 0;
        if (v.done_j >= 0 && v.done_j < TMO) begin
            r.exp_end_j = v.done_j;
            r.exp_tmo   = 1'b0;
        end else begin
            r.exp_end_j = TMO - 1;
            r.exp_tmo   = 1'b1;
        end
        nreq = $countones(v.req_mask & ((16'h1 << (r.exp_end_j + 1)) - 16'h1));
        r.exp_proto = !r.exp_tmo && (nreq < 4);
        return r;
    endfunction

    // Runs one complete request/burst/ack/release exchange and checks every cycle.
    task automatic applyStimulus(input vec_t v);
        int          nreq;
        int          idx;
        logic [15:0] w;
        nreq = 0;
        sticky_align = sticky_align | v.exp_align;

        req     = 1'b1;
        addr_in = v.addr;
        d1      = v.data[0];
        d2      = v.data[1];
        d3      = v.data[2];
        d4      = v.data[3];
        tick();

        for (int k = 0; k <= v.ready_delay; k++) begin
            checkOutput("cmd_valid_cmd", 32'(cmd_valid), 32'd1);
            checkOutput("ctl_addr_cmd", 32'(ctl_addr), 32'(v.exp_addr));
            checkOutput("done_in_cmd", 32'(wr_done), 32'd0);
            if (k == 0) begin
                checkOutput("err_align", 32'(err_align), 32'(sticky_align));
            end
            ready   = (k == v.ready_delay);
            addr_in = 24'($urandom);
            d1      = 16'($urandom);
            d2      = 16'($urandom);
            d3      = 16'($urandom);
            d4      = 16'($urandom);
            tick();
        end
        ready = 1'b0;

        for (int j = 0; j <= v.exp_end_j; j++) begin
            checkOutput("cmd_valid_burst", 32'(cmd_valid), 32'd0);
            checkOutput("done_in_burst", 32'(wr_done), 32'd0);
            checkOutput("ctl_addr_burst", 32'(ctl_addr), 32'(v.exp_addr));
            data_req = v.req_mask[j];
            ctl_done = (j == v.done_j);
            if (v.req_mask[j]) begin
                idx = (nreq > 3) ? 3 : nreq;
                w   = v.data[idx];
                checkOutput("beat_data", 32'(wr_data), 32'(w));
                nreq++;
            end
            tick();
        end
        data_req = 1'b0;
        ctl_done = 1'b0;

        sticky_tmo   = sticky_tmo | v.exp_tmo;
        sticky_proto = sticky_proto | v.exp_proto;
        exp_count    = exp_count + 16'd1;
        checkOutput("done_pulse", 32'(wr_done), 32'd1);
        checkOutput("cmd_valid_ack", 32'(cmd_valid), 32'd0);
        tick();

        checkOutput("done_width", 32'(wr_done), 32'd0);
        checkOutput("wr_count", 32'(wr_count), 32'(exp_count));
        checkOutput("err_timeout", 32'(err_tmo), 32'(sticky_tmo));
        checkOutput("err_proto", 32'(err_proto), 32'(sticky_proto));
        checkOutput("err_align_end", 32'(err_align), 32'(sticky_align));
        for (int h = 0; h < v.hold; h++) begin
            tick();
            checkOutput("cmd_valid_held", 32'(cmd_valid), 32'd0);
            checkOutput("done_held", 32'(wr_done), 32'd0);
        end
        req = 1'b0;
        tick();
        checkOutput("cmd_valid_idle", 32'(cmd_valid), 32'd0);
    endtask

    // Everything visible must be at its reset value.
    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_done"}, 32'(wr_done), 32'd0);
        checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_ctl_addr"}, 32'(ctl_addr), 32'd0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        checkOutput({tag, "_err_align"}, 32'(err_align), 32'd0);
        checkOutput({tag, "_err_tmo"}, 32'(err_tmo), 32'd0);
        checkOutput({tag, "_err_proto"}, 32'(err_proto), 32'd0);
        checkOutput({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin
        vec_t rv;
        tests_run    = 0;
        tests_failed = 0;
        sticky_align = 1'b0;
        sticky_tmo   = 1'b0;
        sticky_proto = 1'b0;
        exp_count    = 16'd0;

        //                    addr        w0        w1        w2        w3     rd  mask      dj  hold exp_addr    ej  al    tm    pr
        table_vecs[0] = mkvec(24'h012340, 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 0, 16'h000F, 3, 0,  24'h012340, 3, 1'b0, 1'b0, 1'b0);
        table_vecs[1] = mkvec(24'hABCDE8, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 5, 16'h0055, 6, 0,  24'hABCDE8, 6, 1'b0, 1'b0, 1'b0);
        table_vecs[2] = mkvec(24'h3FFFFC, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0, 0, 16'h000F, 3, 10, 24'h3FFFFC, 3, 1'b0, 1'b0, 1'b0);
        table_vecs[3] = mkvec(24'h000100, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, 16'h000F, 3, 0,  24'h000100, 3, 1'b0, 1'b0, 1'b0);
        table_vecs[4] = mkvec(24'h000003, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 0, 16'h000F, 3, 0,  24'h000000, 3, 1'b1, 1'b0, 1'b0);
        table_vecs[5] = mkvec(24'h400000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 0, 16'h000F, -1, 0, 24'h400000, 7, 1'b0, 1'b1, 1'b0);
        table_vecs[6] = mkvec(24'h000010, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 0, 16'h0003, 2, 0,  24'h000010, 2, 1'b0, 1'b0, 1'b1);
        table_vecs[7] = mkvec(24'h7FFF04, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 0, 16'h003F, 5, 0,  24'h7FFF04, 5, 1'b0, 1'b0, 1'b0);
        table_vecs[8] = mkvec(24'h123458, 16'h4321, 16'h8765, 16'hCBA9, 16'h0FED, 2, 16'h00AA, 7, 0,  24'h123458, 7, 1'b0, 1'b0, 1'b0);
        table_vecs[9] = mkvec(24'hFEDCBA, 16'h1357, 16'h2468, 16'h369C, 16'h48AD, 0, 16'h0007, 3, 1,  24'hFEDCB8, 3, 1'b1, 1'b0, 1'b1);

        rst      = 1'b1;
        req      = 1'b0;
        addr_in  = '0;
        d1       = '0;
        d2       = '0;
        d3       = '0;
        d4       = '0;
        ready    = 1'b0;
        data_req = 1'b0;
        ctl_done = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Controller strobes while idle must have no effect.
        ready    = 1'b1;
        data_req = 1'b1;
        ctl_done = 1'b1;
        tick();
        tick();
        checkOutput("idle_ignore_done", 32'(wr_done), 32'd0);
        checkOutput("idle_ignore_cmd", 32'(cmd_valid), 32'd0);
        checkOutput("idle_ignore_count", 32'(wr_count), 32'd0);
        checkOutput("idle_ignore_proto", 32'(err_proto), 32'd0);
        ready    = 1'b0;
        data_req = 1'b0;
        ctl_done = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_vecs[i]);
        end

        // Reset in the middle of a burst, after two beats have been taken.
        req     = 1'b1;
        addr_in = 24'h123454;
        d1      = 16'h1A1A;
        d2      = 16'h2B2B;
        d3      = 16'h3C3C;
        d4      = 16'h4D4D;
        tick();
        ready = 1'b1;
        tick();
        ready    = 1'b0;
        data_req = 1'b1;
        tick();
        tick();
        data_req = 1'b0;
        rst      = 1'b1;
        req      = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_values("midreset");
        sticky_align = 1'b0;
        sticky_tmo   = 1'b0;
        sticky_proto = 1'b0;
        exp_count    = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midreset_no_done", 32'(wr_done), 32'd0);
            checkOutput("midreset_no_cmd", 32'(cmd_valid), 32'd0);
        end
        applyStimulus(table_vecs[0]);

        // Randomized plans, expectations from the model.
        for (int n = 0; n < 25; n++) begin
            rv.addr        = 24'($urandom);
            rv.data[0]     = 16'($urandom);
            rv.data[1]     = 16'($urandom);
            rv.data[2]     = 16'($urandom);
            rv.data[3]     = 16'($urandom);
            rv.ready_delay = int'($urandom_range(0, 4));
            rv.req_mask    = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                rv.req_mask = rv.req_mask | 16'h000F;
            end
            rv.done_j      = int'($urandom_range(0, 10));
            rv.hold        = int'($urandom_range(0, 3));
            rv = model(rv);
            applyStimulus(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_wr_port.md
# sdram_wr_port

Responder end of the framebuffer write-request handshake driven by the drawing pipeline (`oSDRAM_Wr_Addr` / `Data1..4` / `Wr_Req` / `iSDRAM_Wr_Done`). It captures one 4-pixel write request, issues it to the SDRAM controller as a single 4-beat write burst, and returns a one-cycle done pulse. It sits between the draw adapter/core and the SDRAM controller command port. It also tracks error status and a write counter for debug LEDs.

## Interface
- `TIMEOUT`, default 1023: maximum cycles allowed from command acceptance to `iCtl_Done` before the burst is aborted.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `iSDRAM_Wr_Req`  in  1  level request from the drawing side; held high until done is seen.
- `iSDRAM_Wr_Addr`  in  24  {bank[23:22], row[21:9], col[8:0]}.
- `iSDRAM_Wr_Data1..4`  in  16 each  RGB565 beats 1..4.
- `oSDRAM_Wr_Done`  out  1  one-cycle completion pulse.
- `oCtl_Cmd_Valid`  out  1  write-burst command valid.
- `iCtl_Cmd_Ready`  in  1  controller accepts the command.
- `oCtl_Addr`  out  24  burst start address; col[1:0] is forced to 00.
- `iCtl_Data_Req`  in  1  controller takes one data beat this cycle.
- `oCtl_Wr_Data`  out  16  current beat; combinational from the beat index.
- `iCtl_Done`  in  1  burst written.
- `oErr_Align`  out  1  sticky: a request had col[1:0] != 0.
- `oErr_Timeout`  out  1  sticky: a burst timed out.
- `oErr_Proto`  out  1  sticky: `iCtl_Done` arrived before 4 beats.
- `oWr_Count`  out  16  completed requests; wraps at 0xFFFF to 0.

## Operation
- States: IDLE, CMD, BURST, ACK, RELEASE.
- **IDLE**
  - When `iSDRAM_Wr_Req`=1, latch the address (col[1:0] cleared) and the four data words.
  - If the original col[1:0] != 0, set `oErr_Align`.
  - Go to CMD.
- **CMD**
  - `oCtl_Cmd_Valid`=1 and `oCtl_Addr` is held stable.
  - On `iCtl_Cmd_Ready`=1, clear the beat counter and the timeout counter, then go to BURST.
  - The timeout does not run in CMD.
- **BURST**
  - `oCtl_Wr_Data` = latched word[beat] for beat 0..3. While beat ≥ 4 it holds word 4.
  - Each `iCtl_Data_Req` increments beat, saturating at 4.
  - On `iCtl_Done`: if beat, counting any same-cycle request, is < 4, set `oErr_Proto`. Go to ACK in either case.
  - The timeout counter increments every cycle. When it reaches `TIMEOUT` without `iCtl_Done`, set `oErr_Timeout` and go to ACK.
- **ACK**
  - `oSDRAM_Wr_Done`=1 for exactly this cycle.
  - Increment `oWr_Count` (including aborted bursts).
  - Go to RELEASE.
- **RELEASE**
  - Wait for `iSDRAM_Wr_Req`=0, then go to IDLE.
  - This prevents a still-high request from being re-accepted as a second write.
- Inputs are sampled only in IDLE. Changes during a burst are ignored.
- `iCtl_Data_Req` and `iCtl_Done` outside BURST are ignored.
- The error flags are sticky and are cleared only by reset.

## Timing
- Reset values:
  - State IDLE.
  - `oSDRAM_Wr_Done`, `oCtl_Cmd_Valid`, and all error flags = 0.
  - `oCtl_Addr` = 0, `oCtl_Wr_Data` = 0, `oWr_Count` = 0.
  - Latched words = 0.
- All outputs are registered except `oCtl_Wr_Data`.
- Request high at cycle t:
  - `oCtl_Cmd_Valid` rises at t+1.
  - With ready at t+1, beats on t+2..t+5, and `iCtl_Done` at t+5: `oSDRAM_Wr_Done` is high at t+6. This is the minimum latency of 6 cycles.
  - RELEASE is entered at t+7. Earliest re-accept is the cycle after req is seen low.
- Reset asserted in any state returns to IDLE on the next edge:
  - No done pulse.
  - `oCtl_Cmd_Valid` drops.
  - In-flight burst is abandoned.
- Data beat k is valid in the same cycle as the k-th `iCtl_Data_Req`. The controller samples it on that edge.

## Test plan
- **Normal write.** Req with addr 0x012340, data 0xF800/0x07E0/0x001F/0xFFFF; controller gives ready immediately and 4 consecutive data requests. Expect:
  - Beats in that order.
  - Done at t+6.
  - `oWr_Count`=1.
  - No error flags.
- **Stalled controller.** Ready delayed 5 cycles; data requests spaced 2 cycles apart. Expect:
  - `oCtl_Addr` stable throughout.
  - Correct beat order.
  - Exactly one done pulse.
- **Held request.** Hold req high for 10 cycles after done. Expect:
  - No second `oCtl_Cmd_Valid`.
  - Req low then high again produces a new burst and `oWr_Count`=2.
- **Misaligned address.** addr 0x000003. Expect `oCtl_Addr`=0x000000 and `oErr_Align`=1 after completion.
- **Controller faults.**
  - `TIMEOUT`=8 and no `iCtl_Done`: expect `oErr_Timeout`=1 and done 9 cycles after ready.
  - `iCtl_Done` after 2 beats: expect `oErr_Proto`=1 and a done pulse.
- **Reset mid-burst.** Reset asserted after beat 2. Expect:
  - All outputs at reset values next cycle.
  - No done pulse.
  - A subsequent request completes normally.
